// File: rtl/fu_issue_arbiter.sv
// Round-robin issue arbiter sharing one functional unit between NUM_REQ issue queues.
// Issue strobe is combinational; the FU input-mux select is registered one cycle later.
module fu_issue_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FU_LATENCY = 1,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] iq_ready,
   input  logic               fu_stall,
   input  logic               flush,
   output logic [NUM_REQ-1:0] iq_issue,
   output logic               sel_valid,
   output logic [IDX_W-1:0]   sel_idx,
   output logic               fu_busy
);

   localparam logic [3:0] BUSY_RELOAD = 4'(FU_LATENCY - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] ptr;
   logic [3:0]       busy_cnt;
   logic             en;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             grant;
   logic [IDX_W-1:0] ptr_next;

   assign en    = !reset && !flush && !fu_stall && (busy_cnt == 4'd0);
   assign grant = en && win_found;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (iq_ready[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      iq_issue = '0;
      if (grant) begin
         iq_issue[win_idx] = 1'b1;
      end
   end

   assign ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
   assign fu_busy  = (busy_cnt != 4'd0);

   // Grant edge: queue dequeues now, select appears on sel_valid/sel_idx next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         busy_cnt  <= 4'd0;
         sel_valid <= 1'b0;
         sel_idx   <= '0;
      end else if (flush) begin
         busy_cnt  <= 4'd0;
         sel_valid <= 1'b0;
      end else if (grant) begin
         ptr       <= ptr_next;
         busy_cnt  <= BUSY_RELOAD;
         sel_valid <= 1'b1;
         sel_idx   <= win_idx;
      end else begin
         sel_valid <= 1'b0;
         // A stalled FU keeps its occupancy frozen.
         if (!fu_stall && busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
         end
      end
   end

endmodule

// File: doc/fu_issue_arbiter.md
# fu_issue_arbiter

Round-robin issue arbiter that shares one functional unit between several issue queues in the Tomasulo backend. Each cycle it looks at every queue's `issue_ready`, drives exactly one queue's `issue` input, and produces a registered select so the FU input mux can steer that queue's `insn_out`/`inp1_out`/`inp2_out`/`dst_out` one cycle later. It also throttles issue while a non-pipelined FU is occupied, and honours FU stall and pipeline flush.

## Interface
- `NUM_REQ`, 4: number of issue queues sharing the FU (2..8).
- `FU_LATENCY`, 1: cycles the FU is occupied per op (1 = fully pipelined, max 15).
- `IDX_W`, `$clog2(NUM_REQ)`: select width (derived, not overridden).

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `iq_ready`  in  NUM_REQ  bit i = `issue_ready` of queue i.
- `fu_stall`  in  1  FU cannot accept a new op this cycle.
- `flush`  in  1  synchronous squash from branch recovery.
- `iq_issue`  out  NUM_REQ  one-hot (or zero) issue strobe; bit i drives `issue` of queue i.
- `sel_valid`  out  1  registered: FU input mux holds a valid op this cycle.
- `sel_idx`  out  IDX_W  registered: queue index feeding the FU mux.
- `fu_busy`  out  1  FU occupancy counter non-zero.

## Operation
- State: round-robin pointer `ptr` (IDX_W), occupancy counter `busy_cnt` (4 bits), `sel_valid`, `sel_idx`.
- Grant enable `en` = !reset && !flush && !fu_stall && (busy_cnt == 0).
- Winner: first i with `iq_ready[i]` set, scanning ptr, ptr+1, ... modulo NUM_REQ. `iq_issue` = one-hot of winner when `en` and any request; else all zero. Combinational from inputs and state.
- On a grant to i at an edge: `ptr` <= (i+1) mod NUM_REQ; `busy_cnt` <= FU_LATENCY-1; `sel_valid` <= 1; `sel_idx` <= i.
- No grant: `ptr` unchanged; `sel_valid` <= 0; `sel_idx` holds; `busy_cnt` decrements if non-zero (saturates at 0).
- `fu_stall` freezes `busy_cnt` (no decrement) and blocks grants; `sel_valid` <= 0.
- `flush`: no grant that cycle; at the edge `busy_cnt` <= 0, `sel_valid` <= 0; `ptr` unchanged. Flush has priority over stall.
- Only one of NUM_REQ strobes ever high; never a strobe to a queue with `iq_ready` low.
- `fu_busy` = (busy_cnt != 0).

## Timing
- Reset (async): `ptr`=0, `busy_cnt`=0, `sel_valid`=0, `sel_idx`=0; `iq_issue`=0 and `fu_busy`=0 for as long as reset is high.
- Request-to-strobe latency 0 cycles (same cycle). Queue dequeues at the edge; `sel_valid`/`sel_idx` valid in the following cycle, aligned with the queue's registered outputs.
- FU_LATENCY=1: back-to-back grants every cycle. FU_LATENCY=L: grants at most once per L cycles absent stall.
- Wrap-around: after granting NUM_REQ-1, `ptr` returns to 0.
- Reset mid-operation drops any pending selection; no strobe during the reset cycle.
- Queue full/empty are not observed directly; an empty queue simply deasserts `iq_ready`.

## Test plan
- Reset then `iq_ready`=4'b1111, FU_LATENCY=1, 5 cycles -> strobes 0001, 0010, 0100, 1000, 0001; `sel_idx` 0,1,2,3,0 one cycle later with `sel_valid`=1.
- `iq_ready`=4'b1010, ptr=0 -> strobe 0010, then 1000, then 0010; queues 0 and 2 never strobed.
- FU_LATENCY=3, `iq_ready`=4'b0001 held -> strobe on cycles 0, 3, 6; `fu_busy`=1 on cycles 1–2 and 4–5.
- FU_LATENCY=3, grant at cycle 0, `fu_stall`=1 on cycles 1–2 -> `busy_cnt` held at 2, next strobe at cycle 5.
- Grant to queue 2 at cycle 0 (FU_LATENCY=3), `flush` at cycle 1 -> no strobe at 1, `fu_busy`=0 at 2, strobe to queue 3 at cycle 2 with `iq_ready`=4'b1111.
- Assert `reset` asynchronously mid-cycle with `sel_valid`=1, `ptr`=2 -> outputs 0 immediately; after release, first grant goes to queue 0.
